// File: rtl/note_player.sv
// Song sequencer: walks the frequency database, latches each note's divider and emits a
// square-wave tone per note followed by a silent gap. NOTE_PLAYER_LOOP_EN repeats the song.
module note_player #(
    parameter int NUM_NOTES   = 10,
    parameter int NOTE_CYCLES = 1000,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] db_entry,
    output logic [3:0] address,
    output logic       tone,
    output logic       note_strobe,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0]       LAST_ADDR = 4'(NUM_NOTES - 1);
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       addr_q, addr_d;
    logic [7:0]       div_q, div_d;
    logic [7:0]       per_q, per_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             tone_q, tone_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            div_q   <= '0;
            per_q   <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            div_q   <= div_d;
            per_q   <= per_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            tone_q  <= tone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        div_d   = div_q;
        per_d   = per_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        tone_d  = tone_q;
        // Dropping en aborts from any active state and outranks note completion.
        if (state_q != S_IDLE && !en) begin
            state_d = S_IDLE;
            addr_d  = '0;
            tone_d  = 1'b0;
            per_d   = '0;
            dur_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d = '0;
                    tone_d = 1'b0;
                    if (en) state_d = S_LOAD;
                end
                S_LOAD: begin
                    div_d   = db_entry;
                    per_d   = '0;
                    dur_d   = '0;
                    tone_d  = 1'b0;
                    state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (dur_q == NOTE_LAST) begin
                        state_d = S_GAP;
                        tone_d  = 1'b0;
                        gap_d   = '0;
                    end else begin
                        dur_d = dur_q + CNT_W'(1);
                        // A zero divider is a rest: the tone stays low for the whole note.
                        if (div_q != 8'd0) begin
                            if (per_q == div_q) begin
                                per_d  = '0;
                                tone_d = ~tone_q;
                            end else begin
                                per_d = per_q + 8'd1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    tone_d = 1'b0;
                    if (gap_q == GAP_LAST) begin
                        if (addr_q < LAST_ADDR) begin
                            addr_d  = addr_q + 4'd1;
                            state_d = S_LOAD;
                        end else begin
`ifdef NOTE_PLAYER_LOOP_EN
                            addr_d  = '0;
                            state_d = S_LOAD;
`else
                            state_d = S_DONE;
`endif
                        end
                    end else begin
                        gap_d = gap_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    tone_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        address     = addr_q;
        tone        = tone_q;
        note_strobe = (state_q == S_LOAD);
        busy        = (state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_GAP);
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: a phase/cycle-count song model drives per-cycle
// comparisons, with directed checks for reset, divider timing, rest, abort and song end.
module tb_note_player;

    localparam int NUM_NOTES   = 10;
    localparam int NOTE_CYCLES = 1000;
    localparam int GAP_CYCLES  = 4;
    localparam int WAIT_BUDGET = 12000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] db_entry;
    logic [3:0] address;
    logic       tone;
    logic       note_strobe;
    logic       busy;
    logic [2:0] state_dbg;
    logic [7:0] rom [16];

    int checks = 0;
    int errors = 0;

    note_player #(
        .NUM_NOTES  (NUM_NOTES),
        .NOTE_CYCLES(NOTE_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .db_entry   (db_entry),
        .address    (address),
        .tone       (tone),
        .note_strobe(note_strobe),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    assign db_entry = rom[address];

    always #5 clk = ~clk;

    // Song model: which phase we are in, which note, and the 1-based cycle within the phase.
    typedef enum int {M_IDLE, M_LOAD, M_PLAY, M_GAP, M_DONE} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_addr  = 0;
    int      m_k     = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= M_IDLE;
            m_addr  <= 0;
            m_k     <= 0;
        end else if (m_phase != M_IDLE && !en) begin
            m_phase <= M_IDLE;
            m_addr  <= 0;
            m_k     <= 0;
        end else begin
            case (m_phase)
                M_IDLE: if (en) m_phase <= M_LOAD;
                M_LOAD: begin
                    m_phase <= M_PLAY;
                    m_k     <= 1;
                end
                M_PLAY: begin
                    if (m_k == NOTE_CYCLES) begin
                        m_phase <= M_GAP;
                        m_k     <= 1;
                    end else begin
                        m_k <= m_k + 1;
                    end
                end
                M_GAP: begin
                    if (m_k == GAP_CYCLES) begin
                        m_k <= 0;
                        if (m_addr < NUM_NOTES - 1) begin
                            m_addr  <= m_addr + 1;
                            m_phase <= M_LOAD;
                        end else begin
`ifdef NOTE_PLAYER_LOOP_EN
                            m_addr  <= 0;
                            m_phase <= M_LOAD;
`else
                            m_phase <= M_DONE;
`endif
                        end
                    end else begin
                        m_k <= m_k + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tone in PLAY cycle k: low for the first d+1 cycles, then alternating every d+1 cycles.
    function automatic logic exp_tone();
        int d;
        if (m_phase != M_PLAY) return 1'b0;
        d = int'(rom[m_addr[3:0]]);
        if (d == 0) return 1'b0;
        return (((m_k - 1) / (d + 1)) % 2) == 1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t addr=%0d state=%0d)",
                     name, act, exp, $time, address, state_dbg);
        end
    endtask

    always @(negedge clk) begin
        check("model_tone", {7'd0, tone}, {7'd0, exp_tone()});
        check("model_address", {4'd0, address}, {4'd0, 4'(m_addr)});
        check("model_strobe", {7'd0, note_strobe}, {7'd0, m_phase == M_LOAD});
        check("model_busy", {7'd0, busy},
              {7'd0, (m_phase == M_LOAD) || (m_phase == M_PLAY) || (m_phase == M_GAP)});
    end

    task automatic wait_for(input mphase_t ph, input int a, input int k, input string name);
        for (int n = 0; n < WAIT_BUDGET; n++) begin
            if (m_phase == ph && m_addr == a && m_k == k) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_%s: condition not reached within %0d cycles", name, WAIT_BUDGET);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_address"}, {4'd0, address}, 8'd0);
        check({name, "_tone"}, {7'd0, tone}, 8'd0);
        check({name, "_strobe"}, {7'd0, note_strobe}, 8'd0);
        check({name, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        rom[0] = 8'h56; rom[1] = 8'h20; rom[2] = 8'h10; rom[3] = 8'h05;
        rom[4] = 8'h30; rom[5] = 8'h09; rom[6] = 8'h40; rom[7] = 8'h00;
        rom[8] = 8'h02; rom[9] = 8'h01;
        for (int i = 10; i < 16; i++) rom[i] = 8'hEE;

        // Reset held with en high.
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("release_strobe", {7'd0, note_strobe}, 8'd1);
        check("release_address", {4'd0, address}, 8'd0);
        check("release_busy", {7'd0, busy}, 8'd1);
        @(negedge clk);
        check("strobe_one_cycle", {7'd0, note_strobe}, 8'd0);

        // Divider 0x56: low through PLAY cycle 87, high 88..174, low again at 175.
        wait_for(M_PLAY, 0, 87, "play0_k87");
        check("div_k87", {7'd0, tone}, 8'd0);
        @(negedge clk);
        check("div_k88", {7'd0, tone}, 8'd1);
        wait_for(M_PLAY, 0, 174, "play0_k174");
        check("div_k174", {7'd0, tone}, 8'd1);
        @(negedge clk);
        check("div_k175", {7'd0, tone}, 8'd0);
        wait_for(M_GAP, 0, 1, "gap0");
        check("gap_tone", {7'd0, tone}, 8'd0);
        wait_for(M_LOAD, 1, 0, "load1");
        check("load1_address", {4'd0, address}, 8'd1);
        check("load1_strobe", {7'd0, note_strobe}, 8'd1);

        // Abort at PLAY cycle 500 of note 3.
        wait_for(M_PLAY, 3, 500, "play3_k500");
        en = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        en = 1'b1;
        @(negedge clk);
        check("restart_strobe", {7'd0, note_strobe}, 8'd1);
        check("restart_address", {4'd0, address}, 8'd0);

        // Synchronous reset during a high tone phase of note 5.
        wait_for(M_PLAY, 5, 15, "play5_k15");
        check("pre_reset_tone", {7'd0, tone}, 8'd1);
        rst_n = 1'b0;
        #2;
        check("no_async_tone", {7'd0, tone}, 8'd1);
        check("no_async_address", {4'd0, address}, 8'd5);
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst_n = 1'b1;

        // Rest note at address 7.
        wait_for(M_LOAD, 7, 0, "load7");
        check("rest_strobe", {7'd0, note_strobe}, 8'd1);
        wait_for(M_PLAY, 7, 500, "play7_k500");
        check("rest_tone", {7'd0, tone}, 8'd0);

`ifdef NOTE_PLAYER_LOOP_EN
        wait_for(M_LOAD, 0, 0, "wrap_load0");
        check("wrap_address", {4'd0, address}, 8'd0);
        check("wrap_strobe", {7'd0, note_strobe}, 8'd1);
`else
        wait_for(M_DONE, 9, 0, "done");
        repeat (5) begin
            check("done_address", {4'd0, address}, 8'd9);
            check("done_busy", {7'd0, busy}, 8'd0);
            check("done_tone", {7'd0, tone}, 8'd0);
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        check_idle_outputs("done_exit");
        en = 1'b1;
        @(negedge clk);
        check("replay_strobe", {7'd0, note_strobe}, 8'd1);
        check("replay_address", {4'd0, address}, 8'd0);
`endif
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
